// File: rtl/round_key_reader.sv
// Streams AES round keys out of a fully expanded key schedule, forward or reverse,
// with a valid/ready handshake towards the round datapath.
module round_key_reader (
    input  logic          clk,
    input  logic          reset,
    input  logic [1919:0] w,
    input  logic          schedDone,
    input  logic [7:0]    Nk,
    input  logic          start,
    input  logic          decrypt,
    input  logic          rkReady,
    output logic          rkValid,
    output logic [127:0]  roundKey,
    output logic [3:0]    roundIdx,
    output logic          lastFlag,
    output logic          busy,
    output logic          doneFlag
);

    typedef enum logic [1:0] {IDLE, WAIT, SERVE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     nr_q, nr_d;
    logic           dec_q, dec_d;
    logic [3:0]     idx_q, idx_d;
    logic [127:0]   key_q, key_d;
    logic           vld_q, vld_d;
    logic           last_q, last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [3:0]     nr_in;
    logic           ld;
    logic [3:0]     ld_idx;

    // Key r occupies words 4r..4r+3, word 0 at the top of w.
    function automatic logic [127:0] key_at(input logic [1919:0] sched, input logic [3:0] r);
        logic [10:0] base;
        base = 11'd1919 - {r, 7'd0};
        return sched[base -: 128];
    endfunction

    always_comb begin
        case (Nk)
            8'd4:    nr_in = 4'd10;
            8'd6:    nr_in = 4'd12;
            default: nr_in = 4'd14;
        endcase
    end

    always_comb begin
        state_d = state_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        key_d   = key_q;
        vld_d   = vld_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ld      = 1'b0;
        ld_idx  = 4'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    nr_d   = nr_in;
                    dec_d  = decrypt;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                    if (schedDone) begin
                        state_d = SERVE;
                        ld      = 1'b1;
                        ld_idx  = decrypt ? nr_in : 4'd0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (schedDone) begin
                    state_d = SERVE;
                    ld      = 1'b1;
                    ld_idx  = dec_q ? nr_q : 4'd0;
                end
            end
            SERVE: begin
                // Losing the schedule mid-pass takes priority over any transfer.
                if (!schedDone) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (vld_q && rkReady) begin
                    if (last_q) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ld     = 1'b1;
                        ld_idx = dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (ld) begin
            idx_d  = ld_idx;
            key_d  = key_at(w, ld_idx);
            vld_d  = 1'b1;
            last_d = dec_d ? (ld_idx == 4'd0) : (ld_idx == nr_d);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            nr_q    <= 4'd14;
            dec_q   <= 1'b0;
            idx_q   <= 4'd0;
            key_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nr_q    <= nr_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rkValid  = vld_q;
    assign roundKey = key_q;
    assign roundIdx = idx_q;
    assign lastFlag = last_q;
    assign busy     = busy_q;
    assign doneFlag = done_q;

endmodule

// File: doc/round_key_reader.md
ROUND_KEY_READER -- requirements
Module: round_key_reader

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset=0 forces reset state immediately, independent of clk.
REQ-004 w  input  1920  expanded key schedule; word i at w[1919-32*i -: 32], i=0..59.
REQ-005 schedDone  input  1  schedule valid flag from key expansion; high = w stable and complete.
REQ-006 Nk  input  8  key length in words: 4→Nr=10, 6→Nr=12, any other value→Nr=14.
REQ-007 start  input  1  begin a pass; sampled only in IDLE.
REQ-008 decrypt  input  1  order select, sampled with start: 0 = forward, 1 = reverse.
REQ-009 rkReady  input  1  consumer accepts roundKey this cycle.
REQ-010 rkValid  output  1  roundKey/roundIdx valid.
REQ-011 roundKey  output  128  round key r = words 4r..4r+3; word 4r in roundKey[127:96].
REQ-012 roundIdx  output  4  index r of the presented key.
REQ-013 lastFlag  output  1  high with rkValid while the final key of the pass is presented.
REQ-014 busy  output  1  high in WAIT or SERVE.
REQ-015 doneFlag  output  1  pass completed; sticky until next accepted start or reset.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, SERVE; all outputs registered.
REQ-017 Nr and decrypt SHALL be latched on the accepted start; later changes to Nk or decrypt SHALL NOT affect the current pass.
REQ-018 IDLE, start=1, schedDone=1 at edge E: after E state=SERVE, rkValid=1, roundKey = first key, doneFlag=0 (one-cycle latency).
REQ-019 IDLE, start=1, schedDone=0: go to WAIT, doneFlag=0, rkValid=0; first key loaded on the edge schedDone is sampled high.
REQ-020 Key sequence SHALL be r=0,1,...,Nr when forward and r=Nr,...,0 when reverse; Nr+1 keys per pass.
REQ-021 Transfer SHALL occur on an edge with rkValid=1 and rkReady=1; roundKey, roundIdx, lastFlag SHALL hold stable while rkValid=1 and rkReady=0.
REQ-022 On a non-final transfer the next key SHALL load on the same edge with rkValid kept at 1 (one key per cycle sustained).
REQ-023 On the final transfer: rkValid=0, lastFlag=0, busy=0, doneFlag=1, state=IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 schedDone=0 sampled in SERVE SHALL abort: state=IDLE, rkValid=0, lastFlag=0, doneFlag=0.
REQ-026 Round index arithmetic SHALL be 4 bits; word offset = 4*r, no wrap; r never leaves 0..Nr.
REQ-027 rkReady SHALL be ignored when rkValid=0.

Reset
REQ-028 reset=0 SHALL set state=IDLE, rkValid=0, roundKey=0, roundIdx=0, lastFlag=0, busy=0, doneFlag=0, latched decrypt=0, Nr=14.
REQ-029 reset asserted mid-pass SHALL discard the pass; after release, no output activity until a new start.

Verification
REQ-030 AES-128 key 000102030405060708090a0b0c0d0e0f expanded, schedDone=1, decrypt=0, rkReady=1 → 11 consecutive keys, roundIdx 0..10, first 000102030405060708090a0b0c0d0e0f, last 13111d7fe3944a17f307a78b4d2b30c5 with lastFlag=1, doneFlag=1 next cycle.
REQ-031 Same schedule, decrypt=1 → first key 13111d7fe3944a17f307a78b4d2b30c5 roundIdx=10, last 000102030405060708090a0b0c0d0e0f roundIdx=0 lastFlag=1.
REQ-032 AES-256 key 00..1f, Nk=8, decrypt=1 → 15 keys, first roundIdx=14 roundKey 24fc79ccbf0979e9371ac23c6d68de36.
REQ-033 rkReady held low 3 cycles at roundIdx=4 → roundKey/roundIdx unchanged those cycles; roundIdx=5 one cycle after rkReady returns high.
REQ-034 start with schedDone=0 for 5 cycles → busy=1, rkValid=0; first key appears the cycle after schedDone rises; start pulsed mid-pass → no effect.
REQ-035 reset=0 asynchronously at roundIdx=6, and separately schedDone dropped at roundIdx=6 → rkValid=0 immediately (reset) or next edge (abort), doneFlag=0, state IDLE.
